// File: rtl/serial_logic_arbiter_if.sv
// Request/operand/result bundle between two requesters and the
// bit-serial logic arbiter.
interface serial_logic_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             req0;
  logic             req1;
  logic [1:0]       op0;
  logic [1:0]       op1;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic             gnt0;
  logic             gnt1;
  logic             busy;
  logic             done;
  logic             done_id;
  logic [WIDTH-1:0] result;

  modport master (
    output req0, req1, op0, op1,
    output a0, b0, a1, b1,
    input  gnt0, gnt1, busy,
    input  done, done_id, result
  );

  modport slave (
    input  req0, req1, op0, op1,
    input  a0, b0, a1, b1,
    output gnt0, gnt1, busy,
    output done, done_id, result
  );
endinterface

// File: rtl/serial_logic_arbiter.sv
// Two-port round-robin arbiter driving a 1-bit logic unit,
// LSB first, one bit per cycle, with a registered result word.
module serial_logic_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  serial_logic_arbiter_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             id_q, id_d;
  logic             last_q, last_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             done_id_q, done_id_d;
  logic             bit_a;
  logic             bit_b;
  logic             bit_fn;
  logic             pick;

  assign bit_a = a_q[cnt_q];
  assign bit_b = b_q[cnt_q];

  // op[1] and op[0] are the two decoder select inputs
  always_comb begin
    bit_fn = 1'b0;
    unique case (1'b1)
      (!op_q[1] && !op_q[0]): bit_fn = bit_a & bit_b;
      (!op_q[1] &&  op_q[0]): bit_fn = bit_a ^ bit_b;
      ( op_q[1] && !op_q[0]): bit_fn = bit_a | bit_b;
      ( op_q[1] &&  op_q[0]): bit_fn = ~bit_a;
      default:                bit_fn = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    sr_d      = sr_q;
    result_d  = result_q;
    cnt_d     = cnt_q;
    id_d      = id_q;
    last_d    = last_q;
    gnt0_d    = 1'b0;
    gnt1_d    = 1'b0;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    // on a tie, the port that did not win last time goes next
    pick      = bus.req1 & (~bus.req0 | ~last_q);
    unique case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          id_d    = pick;
          last_d  = pick;
          op_d    = pick ? bus.op1 : bus.op0;
          a_d     = pick ? bus.a1  : bus.a0;
          b_d     = pick ? bus.b1  : bus.b0;
          cnt_d   = '0;
          gnt0_d  = ~pick;
          gnt1_d  = pick;
          state_d = RUN;
        end
      end
      RUN: begin
        sr_d  = {bit_fn, sr_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          result_d  = sr_d;
          done_d    = 1'b1;
          done_id_d = id_q;
          cnt_d     = '0;
          state_d   = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sr_q      <= '0;
      result_q  <= '0;
      cnt_q     <= '0;
      id_q      <= 1'b0;
      last_q    <= 1'b1;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sr_q      <= sr_d;
      result_q  <= result_d;
      cnt_q     <= cnt_d;
      id_q      <= id_d;
      last_q    <= last_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
    end
  end

  assign bus.gnt0    = gnt0_q;
  assign bus.gnt1    = gnt1_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.done_id = done_id_q;
  assign bus.result  = result_q;
endmodule

// File: tb/tb_serial_logic_arbiter.sv
// Self-checking bench: vector table plus hand sequences,
// results checked against a scoreboard queue on every done pulse.
module tb_serial_logic_arbiter;
  localparam int W = 8;

  typedef struct {
    bit         port;
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
  } vec_t;

  typedef struct {
    bit         id;
    logic [7:0] res;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   n_gnt1;
  int   n_done;
  int   cyc;
  exp_t sb[$];

  serial_logic_arbiter_if #(.WIDTH(W)) bus ();

  serial_logic_arbiter #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model(input logic [1:0] op,
                                       input logic [7:0] a,
                                       input logic [7:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a ^ b;
      2'b10:   return a | b;
      default: return ~a;
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.gnt1) n_gnt1++;
      if (bus.gnt0 || bus.gnt1 || bus.done) begin
        chk("gnt_mutex", 32'(bus.gnt0 & bus.gnt1), 32'd0);
        chk("done_gnt_excl",
            32'(bus.done & (bus.gnt0 | bus.gnt1)), 32'd0);
      end
      if (bus.done) begin
        n_done++;
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("done_id", 32'(bus.done_id), 32'(e.id));
          chk("result", 32'(bus.result), 32'(e.res));
        end
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (bus.busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic drive(input bit p, input logic [1:0] op,
                       input logic [7:0] a, input logic [7:0] b);
    if (p) begin
      bus.req1 = 1'b1;
      bus.op1  = op;
      bus.a1   = a;
      bus.b1   = b;
    end else begin
      bus.req0 = 1'b1;
      bus.op0  = op;
      bus.a0   = a;
      bus.b0   = b;
    end
  endtask

  task automatic run_op(input bit p, input logic [1:0] op,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp, input bit hold);
    wait_idle();
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    drive(p, op, a, b);
    sb.push_back('{p, exp});
    @(posedge clk);
    @(negedge clk);
    chk("gnt_own", 32'(p ? bus.gnt1 : bus.gnt0), 32'd1);
    chk("gnt_other", 32'(p ? bus.gnt0 : bus.gnt1), 32'd0);
    chk("busy_rise", 32'(bus.busy), 32'd1);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    for (int k = 2; k <= 8; k++) begin
      @(negedge clk);
      chk("run_busy", 32'(bus.busy), 32'd1);
      chk("run_no_done", 32'(bus.done), 32'd0);
    end
    @(negedge clk);
    chk("done_pulse", 32'(bus.done), 32'd1);
    chk("done_busy", 32'(bus.busy), 32'd1);
    @(negedge clk);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("done_fall", 32'(bus.done), 32'd0);
    if (hold) begin
      repeat (5) @(negedge clk);
      chk("result_hold", 32'(bus.result), 32'(exp));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    vec_t tbl[10];
    int   t0;
    int   g1;
    int   d0;
    int   n;
    logic [7:0] ra;
    logic [7:0] rb;
    logic [1:0] rop;

    n_checks = 0;
    n_fail   = 0;
    n_gnt1   = 0;
    n_done   = 0;
    cyc      = 0;
    rst_n    = 1'b0;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.op0  = '0;
    bus.op1  = '0;
    bus.a0   = '0;
    bus.b0   = '0;
    bus.a1   = '0;
    bus.b1   = '0;

    tbl[0] = '{1'b0, 2'b00, 8'hCA, 8'h0F, 8'h0A};
    tbl[1] = '{1'b1, 2'b01, 8'hCA, 8'h0F, 8'hC5};
    tbl[2] = '{1'b1, 2'b10, 8'hCA, 8'h0F, 8'hCF};
    tbl[3] = '{1'b1, 2'b11, 8'hCA, 8'h0F, 8'h35};
    tbl[4] = '{1'b1, 2'b11, 8'hCA, 8'hFF, 8'h35};
    tbl[5] = '{1'b0, 2'b11, 8'h00, 8'hAA, 8'hFF};
    for (int i = 6; i < 10; i++) begin
      ra  = 8'($urandom());
      rb  = 8'($urandom());
      rop = 2'($urandom_range(0, 3));
      tbl[i] = '{1'(i & 1), rop, ra, rb, model(rop, ra, rb)};
    end

    repeat (2) @(negedge clk);
    chk("rst_gnt0", 32'(bus.gnt0), 32'd0);
    chk("rst_gnt1", 32'(bus.gnt1), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_done_id", 32'(bus.done_id), 32'd0);
    chk("rst_result", 32'(bus.result), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_op(tbl[i].port, tbl[i].op, tbl[i].a, tbl[i].b,
             tbl[i].exp, i == 0);
    end

    // tie after reset: port 0 first, then alternation
    do_reset();
    wait_idle();
    drive(1'b0, 2'b00, 8'hCA, 8'h0F);
    drive(1'b1, 2'b10, 8'h33, 8'h55);
    sb.push_back('{1'b0, 8'h0A});
    sb.push_back('{1'b1, 8'h77});
    sb.push_back('{1'b0, 8'h0A});
    @(posedge clk);
    @(negedge clk);
    chk("tie_gnt0_t1", 32'(bus.gnt0), 32'd1);
    chk("tie_gnt1_t1", 32'(bus.gnt1), 32'd0);
    repeat (8) @(negedge clk);
    chk("tie_done_t9", 32'(bus.done), 32'd1);
    repeat (2) @(negedge clk);
    chk("tie_gnt1_t11", 32'(bus.gnt1), 32'd1);
    repeat (8) @(negedge clk);
    chk("tie_done_t19", 32'(bus.done), 32'd1);
    repeat (2) @(negedge clk);
    chk("tie_gnt0_t21", 32'(bus.gnt0), 32'd1);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    wait_idle();
    chk("tie_sb_empty", 32'(sb.size()), 32'd0);

    // req1 held, operands replaced after each grant
    wait_idle();
    ra = 8'h5A;
    rb = 8'h3C;
    drive(1'b1, 2'b01, ra, rb);
    sb.push_back('{1'b1, model(2'b01, ra, rb)});
    t0 = 0;
    for (int g = 0; g < 3; g++) begin
      n = 0;
      @(negedge clk);
      while (!bus.gnt1 && n < 30) begin
        @(negedge clk);
        n++;
      end
      chk("hold_gnt1_seen", 32'(bus.gnt1), 32'd1);
      if (g > 0) chk("hold_period", 32'(cyc - t0), 32'd10);
      t0 = cyc;
      if (g < 2) begin
        ra  = 8'($urandom());
        rb  = 8'($urandom());
        rop = 2'($urandom_range(0, 3));
        drive(1'b1, rop, ra, rb);
        sb.push_back('{1'b1, model(rop, ra, rb)});
      end else begin
        bus.req1 = 1'b0;
        bus.a1   = 8'hFF;
        bus.b1   = 8'hFF;
      end
    end
    wait_idle();
    chk("hold_sb_empty", 32'(sb.size()), 32'd0);

    // asynchronous reset in the 4th RUN cycle
    wait_idle();
    drive(1'b0, 2'b01, 8'hFF, 8'h00);
    @(posedge clk);
    @(negedge clk);
    chk("abort_gnt0", 32'(bus.gnt0), 32'd1);
    bus.req0 = 1'b0;
    repeat (3) @(negedge clk);
    d0 = n_done;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_gnt", 32'(bus.gnt0 | bus.gnt1), 32'd0);
    chk("abort_result", 32'(bus.result), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort_no_done", 32'(n_done - d0), 32'd0);
    run_op(1'b0, 2'b00, 8'hF0, 8'h3C, 8'h30, 1'b0);

    // request during RUN is dropped before DONE
    wait_idle();
    drive(1'b0, 2'b00, 8'hCA, 8'h0F);
    sb.push_back('{1'b0, 8'h0A});
    @(posedge clk);
    @(negedge clk);
    chk("ign_gnt0", 32'(bus.gnt0), 32'd1);
    bus.req0 = 1'b0;
    g1 = n_gnt1;
    repeat (2) @(negedge clk);
    drive(1'b1, 2'b10, 8'h11, 8'h22);
    repeat (4) @(negedge clk);
    bus.req1 = 1'b0;
    repeat (2) @(negedge clk);
    chk("ign_done", 32'(bus.done), 32'd1);
    @(negedge clk);
    chk("ign_idle", 32'(bus.busy), 32'd0);
    repeat (4) @(negedge clk);
    chk("ign_no_gnt1", 32'(n_gnt1 - g1), 32'd0);
    chk("ign_still_idle", 32'(bus.busy), 32'd0);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
